// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore-style multi-cycle control unit.
// Sequences each instruction through IF/ID/EXE/MEM/WB and drives datapath
// enables and selects. Strobes are gated by the registered state; selects
// are pure opcode decode (plus ALU flags for branch PCSrc).
// Optional feature macro: CTRL_HALT_EN -- when defined, the halt opcode
// parks the machine in an absorbing sHALT state left only by Reset; when
// undefined, halt is an ordinary undefined opcode (nop).
module multi_cycle_control #(
  parameter int OPCODE_W = 6
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  input  logic                Sign,
  output logic [3:0]          State,
  output logic                PCWre,
  output logic                IRWre,
  output logic                RegWre,
  output logic                mRD,
  output logic                mWR,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                ExtSel,
  output logic [1:0]          RegDst,
  output logic                WrRegDSrc,
  output logic                DBDataSrc,
  output logic [1:0]          PCSrc,
  output logic [2:0]          ALUOp
);

  localparam logic [OPCODE_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OPCODE_W-1:0] OP_OR    = 6'b010010;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b010011;
  localparam logic [OPCODE_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPCODE_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b111000;
  localparam logic [OPCODE_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b111010;
`ifdef CTRL_HALT_EN
  localparam logic [OPCODE_W-1:0] OP_HALT  = 6'b111111;
`endif

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  state_t state, state_nxt;

  logic is_jump;
  logic is_jal;
  logic is_sw;
  logic is_lw;

  assign is_jump = (Opcode == OP_J) || (Opcode == OP_JR) || (Opcode == OP_JAL);
  assign is_jal  = (Opcode == OP_JAL);
  assign is_sw   = (Opcode == OP_SW);
  assign is_lw   = (Opcode == OP_LW);

  assign State = state;

  // State register; synchronous reset wins over any transition.
  always_ff @(posedge CLK) begin
    if (Reset) state <= S_IF;
    else       state <= state_nxt;
  end

  // Next-state decode; undefined opcodes fall back to fetch as a nop.
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        case (Opcode)
          OP_J, OP_JR, OP_JAL:          state_nxt = S_IF;
          OP_BEQ, OP_BNE, OP_BLTZ:      state_nxt = S_EXE_BR;
          OP_LW, OP_SW:                 state_nxt = S_EXE_LS;
          OP_ADD, OP_SUB, OP_ADDIU,
          OP_AND, OP_ANDI, OP_OR,
          OP_ORI, OP_SLL, OP_SLTI:      state_nxt = S_EXE_AL;
`ifdef CTRL_HALT_EN
          OP_HALT:                      state_nxt = S_HALT;
`endif
          default:                      state_nxt = S_IF;
        endcase
      end
      S_EXE_AL: state_nxt = S_WB_AL;
      S_EXE_BR: state_nxt = S_IF;
      S_EXE_LS: state_nxt = S_MEM;
      S_MEM:    state_nxt = is_lw ? S_WB_LD : S_IF;
      S_WB_AL:  state_nxt = S_IF;
      S_WB_LD:  state_nxt = S_IF;
`ifdef CTRL_HALT_EN
      S_HALT:   state_nxt = S_HALT;
`endif
      default:  state_nxt = S_IF;
    endcase
  end

  // State-gated strobes: PC is written only in the last state of an instruction.
  always_comb begin
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    case (state)
      S_IF: IRWre = 1'b1;
      S_ID: begin
        PCWre  = is_jump;
        RegWre = is_jal;
      end
      S_EXE_BR: PCWre = 1'b1;
      S_MEM: begin
        PCWre = is_sw;
        mWR   = is_sw;
        mRD   = is_lw;
      end
      S_WB_AL, S_WB_LD: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath selects: opcode decode only, identical in every state.
  always_comb begin
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b1;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b1;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = 3'b000;
    case (Opcode)
      OP_ADD:   begin RegDst = 2'b10; end
      OP_SUB:   begin RegDst = 2'b10; ALUOp = 3'b001; end
      OP_ADDIU: begin RegDst = 2'b01; ALUSrcB = 1'b1; end
      OP_AND:   begin RegDst = 2'b10; ALUOp = 3'b100; end
      OP_ANDI:  begin RegDst = 2'b01; ALUSrcB = 1'b1; ExtSel = 1'b0; ALUOp = 3'b100; end
      OP_OR:    begin RegDst = 2'b10; ALUOp = 3'b011; end
      OP_ORI:   begin RegDst = 2'b01; ALUSrcB = 1'b1; ExtSel = 1'b0; ALUOp = 3'b011; end
      OP_SLL:   begin RegDst = 2'b10; ALUSrcA = 1'b1; ALUOp = 3'b010; end
      OP_SLTI:  begin RegDst = 2'b01; ALUSrcB = 1'b1; ALUOp = 3'b101; end
      OP_SW:    begin RegDst = 2'b01; ALUSrcB = 1'b1; end
      OP_LW:    begin RegDst = 2'b01; ALUSrcB = 1'b1; DBDataSrc = 1'b1; end
      OP_BEQ:   begin RegDst = 2'b01; ALUOp = 3'b001; PCSrc = Zero  ? 2'b01 : 2'b00; end
      OP_BNE:   begin RegDst = 2'b01; ALUOp = 3'b001; PCSrc = !Zero ? 2'b01 : 2'b00; end
      OP_BLTZ:  begin RegDst = 2'b01; ALUOp = 3'b001; PCSrc = Sign  ? 2'b01 : 2'b00; end
      OP_J:     begin PCSrc = 2'b11; end
      OP_JR:    begin RegDst = 2'b10; PCSrc = 2'b10; end
      OP_JAL:   begin RegDst = 2'b00; WrRegDSrc = 1'b0; PCSrc = 2'b11; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: randomized bench for multi_cycle_control with a
// behavioural reference model (instruction class -> state path, strobes by
// position in the path, selects from opcode tables).
module tb_multi_cycle_control;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
  localparam logic [5:0] AND_ = 6'b010000, ANDI = 6'b010001, OR_ = 6'b010010, ORI = 6'b010011;
  localparam logic [5:0] SLL = 6'b011000, SLTI = 6'b100110;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001;
  localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
  localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  localparam int C_JMP = 0, C_BR = 1, C_SW = 2, C_LW = 3, C_ALU = 4, C_NOP = 5, C_HALT = 6;

  logic       CLK;
  logic       Reset;
  logic [5:0] Opcode;
  logic       Zero;
  logic       Sign;
  logic [3:0] State;
  logic       PCWre, IRWre, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, ExtSel, WrRegDSrc, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];

  multi_cycle_control #(.OPCODE_W(6)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Sign(Sign),
    .State(State), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
    .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .ALUOp(ALUOp)
  );

  // Clock and watchdog.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  wire [16:0] act_ctl = {PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel,
                         RegDst, WrRegDSrc, DBDataSrc, PCSrc, ALUOp};

  // ---------------- reference model ----------------
  function automatic int cls_of(input logic [5:0] op);
    if (op == J || op == JR || op == JAL) return C_JMP;
    if (op == BEQ || op == BNE || op == BLTZ) return C_BR;
    if (op == SW) return C_SW;
    if (op == LW) return C_LW;
    if (op inside {ADD, SUB, ADDIU, AND_, ANDI, OR_, ORI, SLL, SLTI}) return C_ALU;
`ifdef CTRL_HALT_EN
    if (op == HALT) return C_HALT;
`endif
    return C_NOP;
  endfunction

  // Fill exp_q with the state path an instruction class walks through.
  function automatic void build_path(input int c);
    exp_q.delete();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    case (c)
      C_BR:  exp_q.push_back(4'd3);
      C_ALU: begin exp_q.push_back(4'd2); exp_q.push_back(4'd6); end
      C_SW:  begin exp_q.push_back(4'd4); exp_q.push_back(4'd5); end
      C_LW:  begin exp_q.push_back(4'd4); exp_q.push_back(4'd5); exp_q.push_back(4'd7); end
      default: ;
    endcase
  endfunction

  // {ALUSrcA, ALUSrcB, ExtSel, RegDst, WrRegDSrc, DBDataSrc, PCSrc, ALUOp}
  function automatic logic [11:0] sel_model(input logic [5:0] op, input logic z, input logic s);
    logic       srca, srcb, ext, wrs, dbs;
    logic [1:0] rd, pcs;
    logic [2:0] aop;
    srca = (op == SLL);
    srcb = op inside {ADDIU, ANDI, ORI, SLTI, LW, SW};
    ext  = !(op inside {ANDI, ORI});
    if (op == JAL) rd = 2'b00;
    else if (op inside {ADD, SUB, AND_, OR_, SLL, JR}) rd = 2'b10;
    else if (op inside {ADDIU, ANDI, ORI, SLTI, LW, SW, BEQ, BNE, BLTZ}) rd = 2'b01;
    else rd = 2'b00;
    wrs = (op != JAL);
    dbs = (op == LW);
    if (op == J || op == JAL) pcs = 2'b11;
    else if (op == JR) pcs = 2'b10;
    else if ((op == BEQ && z) || (op == BNE && !z) || (op == BLTZ && s)) pcs = 2'b01;
    else pcs = 2'b00;
    if (op inside {SUB, BEQ, BNE, BLTZ}) aop = 3'd1;
    else if (op == SLL) aop = 3'd2;
    else if (op inside {OR_, ORI}) aop = 3'd3;
    else if (op inside {AND_, ANDI}) aop = 3'd4;
    else if (op == SLTI) aop = 3'd5;
    else aop = 3'd0;
    return {srca, srcb, ext, rd, wrs, dbs, pcs, aop};
  endfunction

  // ---------------- driver ----------------
  // Entered just after a posedge with the DUT in fetch; runs one whole
  // instruction and compares every cycle against the model.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
    int c, n;
    logic pcw, irw, rgw, rd, wr;
    logic [16:0] exp_ctl;
    Opcode = op; Zero = z; Sign = s;
    c = cls_of(op);
    build_path(c);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      irw = (i == 0);
      pcw = (i == n - 1) && (c != C_NOP);
      rgw = ((c == C_ALU || c == C_LW) && i == n - 1) || (op == JAL && i == 1);
      rd  = (c == C_LW) && (i == 3);
      wr  = (c == C_SW) && (i == 3);
      exp_ctl = {pcw, irw, rgw, rd, wr, sel_model(op, z, s)};
      total++;
      if (State !== exp_q[0]) begin
        bad++;
        $display("FAIL state op=%b cyc=%0d got=%0d exp=%0d", op, i, State, exp_q[0]);
      end
      total++;
      if (act_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL ctl op=%b cyc=%0d st=%0d got=%b exp=%b", op, i, State, act_ctl, exp_ctl);
      end
      void'(exp_q.pop_front());
      @(posedge CLK); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Reset = 1'b1; Opcode = 6'($urandom_range(0, 63)); Zero = 1'b0; Sign = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", State); end
    total++;
    if ({PCWre, IRWre, RegWre, mRD, mWR} !== 5'b01000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=01000", {PCWre, IRWre, RegWre, mRD, mWR});
    end
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    run_instr(ADD, 1'b0, 1'b0);
    run_instr(ADD, 1'b1, 1'b1);
  endtask

  task automatic test_lw;
    run_instr(LW, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_instr(SW, 1'b0, 1'b0);
  endtask

  task automatic test_branch;
    run_instr(BEQ, 1'b1, 1'b0);
    run_instr(BEQ, 1'b0, 1'b1);
    run_instr(BNE, 1'b0, 1'b0);
    run_instr(BNE, 1'b1, 1'b0);
    run_instr(BLTZ, 1'b0, 1'b1);
    run_instr(BLTZ, 1'b1, 1'b0);
  endtask

  task automatic test_jump;
    run_instr(JAL, 1'b0, 1'b0);
    run_instr(J, 1'b1, 1'b0);
    run_instr(JR, 1'b0, 1'b1);
  endtask

  task automatic test_halt;
`ifdef CTRL_HALT_EN
    Opcode = HALT; Zero = 1'b0; Sign = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    total++;
    if (State !== 4'd1 || {PCWre, RegWre} !== 2'b00) begin
      bad++; $display("FAIL halt_id got st=%0d pcw=%b regw=%b exp st=1 pcw=0 regw=0", State, PCWre, RegWre);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      total++;
      if (State !== 4'd8 || act_ctl !== {5'b00000, sel_model(HALT, 1'b0, 1'b0)}) begin
        bad++; $display("FAIL halt_park cyc=%0d got st=%0d ctl=%b exp st=8", i, State, act_ctl);
      end
    end
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (State !== 4'd0 || IRWre !== 1'b1) begin
      bad++; $display("FAIL halt_exit got st=%0d irw=%b exp st=0 irw=1", State, IRWre);
    end
    Reset = 1'b0;
`else
    run_instr(HALT, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_sw;
    Opcode = SW; Zero = 1'b0; Sign = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    @(negedge CLK);
    total++;
    if (State !== 4'd5 || mWR !== 1'b1) begin
      bad++; $display("FAIL sw_mem got st=%0d mwr=%b exp st=5 mwr=1", State, mWR);
    end
    Reset = 1'b1;
    @(posedge CLK); #1;
    total++;
    if (State !== 4'd0 || {mWR, mRD, PCWre, RegWre, IRWre} !== 5'b00001) begin
      bad++; $display("FAIL sw_abort got st=%0d strobes=%b exp st=0 strobes=00001",
                      State, {mWR, mRD, PCWre, RegWre, IRWre});
    end
    Reset = 1'b0;
  endtask

  task automatic test_random;
    logic [5:0] ops [18];
    logic [5:0] op;
    ops = '{ADD, SUB, ADDIU, AND_, ANDI, OR_, ORI, SLL, SLTI,
            SW, LW, BEQ, BNE, BLTZ, J, JR, JAL, 6'b101010};
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 17)];
`ifdef CTRL_HALT_EN
      if (op == HALT) op = ADD;
`endif
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  // Test sequence and summary.
  initial begin
    Reset = 1'b1; Opcode = 6'd0; Zero = 1'b0; Sign = 1'b0;
    test_reset;
    test_back_to_back;
    test_lw;
    test_branch;
    test_jump;
    test_reset_mid_sw;
    test_random;
    test_halt;
    test_reset;
    run_instr(ORI, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
